// File: rtl/x_500_mod_53_loader_pkg.sv
// Shared constants and state encoding for the 500-bit mod-53 operand loader.
package x_500_mod_53_loader_pkg;

  localparam int W_IN     = 32;
  localparam int X_W      = 500;
  localparam int R_W      = 6;
  localparam int MOD      = 53;
  localparam int N_WORDS  = 16;
  localparam int CNT_W    = 4;
  // Number of operand bits carried by the final (partial) word.
  localparam int TOP_BITS = X_W - (N_WORDS - 1) * W_IN;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    EVAL = 2'd1,
    OUT  = 2'd2
  } state_e;

endpackage

// File: rtl/x_500_operand_reg.sv
// Word-addressed 500-bit operand register; the top word keeps only its low
// TOP_BITS bits and flags any nonzero bit above them.
module x_500_operand_reg
  import x_500_mod_53_loader_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             we,
  input  logic [CNT_W-1:0] idx,
  input  logic [W_IN-1:0]  din,
  output logic [X_W-1:0]   x,
  output logic             top_err
);

  localparam logic [CNT_W-1:0] TOP_IDX = CNT_W'(N_WORDS - 1);

  logic [X_W-1:0] x_d, x_q;

  always_comb begin
    x_d = x_q;
    if (clear) begin
      x_d = '0;
    end else if (we) begin
      for (int k = 0; k < N_WORDS - 1; k++) begin
        if (idx == CNT_W'(k)) x_d[k*W_IN +: W_IN] = din;
      end
      if (idx == TOP_IDX) x_d[X_W-1 -: TOP_BITS] = din[TOP_BITS-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) x_q <= '0;
    else        x_q <= x_d;
  end

  assign x       = x_q;
  assign top_err = (idx == TOP_IDX) && (|din[W_IN-1:TOP_BITS]);

endmodule

// File: rtl/x_500_mod_53_loader.sv
// Streams a 500-bit operand in 32-bit words, exposes it to the external
// mod-53 reduction stage, and returns the captured residue with an error flag.
module x_500_mod_53_loader
  import x_500_mod_53_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [W_IN-1:0]   in_data,
  input  logic              in_last,
  output logic [X_W-1:0]    x_out,
  input  logic [R_W-1:0]    r_in,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [R_W-1:0]    res_data,
  output logic              res_err
);

  localparam logic [CNT_W-1:0] TOP_IDX = CNT_W'(N_WORDS - 1);

  state_e           state_d, state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             err_d, err_q;
  logic             res_valid_d, res_valid_q;
  logic [R_W-1:0]   res_data_d, res_data_q;
  logic             res_err_d, res_err_q;
  logic             op_clear, op_we, top_err;

  x_500_operand_reg u_operand (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (op_clear),
    .we      (op_we),
    .idx     (cnt_q),
    .din     (in_data),
    .x       (x_out),
    .top_err (top_err)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_err_d   = res_err_q;
    op_clear    = 1'b0;
    op_we       = 1'b0;
    case (state_q)
      LOAD: begin
        if (in_valid) begin
          op_we = 1'b1;
          cnt_d = (cnt_q == TOP_IDX) ? cnt_q : cnt_q + 4'd1;
          // The sixteenth word always closes the operand, with or without in_last.
          if (cnt_q == TOP_IDX) begin
            state_d = EVAL;
            if (!in_last || top_err) err_d = 1'b1;
          end else if (in_last) begin
            state_d = EVAL;
          end
        end
      end
      EVAL: begin
        res_data_d  = r_in;
        res_valid_d = 1'b1;
        res_err_d   = err_q | (r_in >= R_W'(MOD));
        state_d     = OUT;
      end
      OUT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          op_clear    = 1'b1;
          cnt_d       = '0;
          err_d       = 1'b0;
          state_d     = LOAD;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LOAD;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_err_q   <= res_err_d;
    end
  end

  assign in_ready  = rst_n && (state_q == LOAD);
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_err   = res_err_q;

endmodule

// File: tb/tb_x_500_mod_53_loader.sv
// Directed bench for x_500_mod_53_loader: an arithmetic operand/residue model
// checked every cycle, plus hand-computed residues for each directed operand.
module tb_x_500_mod_53_loader;
  import x_500_mod_53_loader_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_last = 1'b0;
  logic         res_ready = 1'b0;
  logic [31:0]  in_data = '0;
  logic         in_ready, res_valid, res_err;
  logic [499:0] x_out;
  logic [5:0]   r_in, res_data;
  logic         ovr_en = 1'b0;
  logic [5:0]   ovr_val = '0;

  int errors = 0;
  int checks = 0;

  // Behavioural view: the operand as a number, how many words have arrived,
  // whether a framing fault was seen, and whether a result is due or on offer.
  logic [499:0] m_operand = '0;
  int           m_n = 0;
  bit           m_bad = 1'b0;
  bit           m_due = 1'b0;
  bit           m_offer = 1'b0;
  logic [5:0]   m_res = '0;
  bit           m_rerr = 1'b0;

  always #5 clk = ~clk;

  function automatic logic [5:0] mod53(input logic [499:0] v);
    int r = 0;
    for (int i = 499; i >= 0; i--) r = (r * 2 + (v[i] ? 1 : 0)) % 53;
    return 6'(r);
  endfunction

  // Stand-in for the parent's reduction stage, with an override to reach
  // residues that a correct reducer never produces.
  assign r_in = ovr_en ? ovr_val : mod53(x_out);

  x_500_mod_53_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .x_out     (x_out),
    .r_in      (r_in),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_err   (res_err)
  );

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_operand <= '0;
      m_n       <= 0;
      m_bad     <= 1'b0;
      m_due     <= 1'b0;
      m_offer   <= 1'b0;
      m_res     <= '0;
      m_rerr    <= 1'b0;
    end else if (m_offer) begin
      if (res_ready) begin
        m_offer   <= 1'b0;
        m_operand <= '0;
        m_n       <= 0;
        m_bad     <= 1'b0;
      end
    end else if (m_due) begin
      m_due   <= 1'b0;
      m_offer <= 1'b1;
      m_res   <= ovr_en ? ovr_val : mod53(m_operand);
      m_rerr  <= m_bad || ((ovr_en ? ovr_val : mod53(m_operand)) >= 6'd53);
    end else if (in_valid) begin
      if (m_n < 15) begin
        m_operand <= m_operand | (500'(in_data) << (32 * m_n));
      end else begin
        m_operand <= m_operand | (500'(in_data[19:0]) << 480);
        if (!in_last || in_data[31:20] != 12'd0) m_bad <= 1'b1;
      end
      m_n <= m_n + 1;
      if (in_last || m_n == 15) m_due <= 1'b1;
    end
  end

  task automatic check_output(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check_output("in_ready", 512'(in_ready), 512'(rst_n && !m_due && !m_offer));
    check_output("x_out", 512'(x_out), 512'(m_operand));
    check_output("res_valid", 512'(res_valid), 512'(m_offer));
    if (m_offer) begin
      check_output("res_data", 512'(res_data), 512'(m_res));
      check_output("res_err", 512'(res_err), 512'(m_rerr));
    end
  end

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic apply_stimulus(input logic [31:0] data, input logic last);
    int tries = 0;
    in_valid = 1'b1;
    in_data  = data;
    in_last  = last;
    while (!in_ready && tries < 50) begin
      @(negedge clk);
      tries++;
    end
    if (tries >= 50) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: got in_ready=0 for 50 cycles expected 1");
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_full(input logic [31:0] fill, input logic [31:0] top, input logic last);
    for (int i = 0; i < 15; i++) apply_stimulus(fill, 1'b0);
    apply_stimulus(top, last);
  endtask

  task automatic expect_result(input string tag, input logic [5:0] exp_data, input logic exp_err,
                               input int hold);
    int n = 1;
    while (!res_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_output({tag, "_latency"}, 512'(n), 512'(2));
    check_output({tag, "_data"}, 512'(res_data), 512'(exp_data));
    check_output({tag, "_err"}, 512'(res_err), 512'(exp_err));
    if (hold > 0) begin
      in_valid = 1'b1;
      in_data  = 32'hDEAD_BEEF;
      in_last  = 1'b1;
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_output({tag, "_hold_ready"}, 512'(in_ready), 512'(0));
      check_output({tag, "_hold_valid"}, 512'(res_valid), 512'(1));
      check_output({tag, "_hold_data"}, 512'(res_data), 512'(exp_data));
      check_output({tag, "_hold_err"}, 512'(res_err), 512'(exp_err));
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0;
    check_output({tag, "_released"}, 512'(res_valid), 512'(0));
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_output("rst_in_ready", 512'(in_ready), 512'(0));
    check_output("rst_x_out", 512'(x_out), 512'(0));
    check_output("rst_res_valid", 512'(res_valid), 512'(0));
    check_output("rst_res_data", 512'(res_data), 512'(0));
    check_output("rst_res_err", 512'(res_err), 512'(0));
    rst_n = 1'b1;
    @(negedge clk);

    apply_stimulus(32'h0000_0035, 1'b1);
    check_output("t1_x_out", 512'(x_out), 512'(53));
    expect_result("t1", 6'd0, 1'b0, 0);

    apply_stimulus(32'h0000_0064, 1'b1);
    expect_result("t2", 6'd47, 1'b0, 0);

    send_full(32'h0, 32'h0008_0000, 1'b1);
    expect_result("t3_2pow499", 6'd21, 1'b0, 0);

    send_full(32'hFFFF_FFFF, 32'h000F_FFFF, 1'b1);
    expect_result("t4_allones", 6'd41, 1'b0, 0);

    // 2^480 mod 53 = 2^12 mod 53 = 15 (2^52 = 1 mod 53).
    send_full(32'h0, 32'hFFF0_0001, 1'b0);
    expect_result("t5_frame", 6'd15, 1'b1, 5);

    apply_stimulus(32'h0000_0064, 1'b1);
    expect_result("t6_after_err", 6'd47, 1'b0, 0);

    send_full(32'h0, 32'h0000_0001, 1'b0);
    expect_result("t7_nolast", 6'd15, 1'b1, 0);

    send_full(32'h0, 32'h0010_0000, 1'b1);
    expect_result("t8_bit20", 6'd0, 1'b1, 0);

    ovr_en  = 1'b1;
    ovr_val = 6'd52;
    apply_stimulus(32'h0000_0001, 1'b1);
    expect_result("t9_r52", 6'd52, 1'b0, 0);
    ovr_val = 6'd53;
    apply_stimulus(32'h0000_0001, 1'b1);
    expect_result("t9_r53", 6'd53, 1'b1, 0);
    ovr_en = 1'b0;

    for (int i = 0; i < 7; i++) apply_stimulus(32'(i + 1), 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_output("t10_rst_x_out", 512'(x_out), 512'(0));
    check_output("t10_rst_valid", 512'(res_valid), 512'(0));
    check_output("t10_rst_ready", 512'(in_ready), 512'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    apply_stimulus(32'h0000_006A, 1'b1);
    expect_result("t10_after_rst", 6'd0, 1'b0, 0);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
